ext_intr_ctrl: RTL

External interrupt controller that sits between asynchronous device interrupt lines and the single-cycle CPU's trap logic. It synchronizes up to 15 sources and captures them as edge- or level-triggered requests. It drives the machine external interrupt pending bit (mip[11] / intr_synced) and presents a claim ID. It completes the request/acknowledge handshake with the control unit's `intr_ack` and the handler's completion.

---
 rtl/ext_intr_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ext_intr_ctrl.sv
// ============================================================================
// Module   : ext_intr_ctrl
// Brief    : Gateway that turns async device IRQs into a single claimed meip.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ext_intr_ctrl #(
   parameter int NSRC        = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_in,
   input  logic [NSRC-1:0] edge_mode,
   input  logic [NSRC-1:0] src_en,
   input  logic            intr_ack,
   input  logic            complete,
   output logic            meip,
   output logic [3:0]      claim_id,
   output logic            busy,
   output logic [NSRC-1:0] pending
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e          state_q;
   logic [NSRC-1:0] sync_q [SYNC_STAGES];
   logic [NSRC-1:0] s_w;
   logic [NSRC-1:0] s_d_q;
   logic [NSRC-1:0] pend_q;
   logic [NSRC-1:0] pend_d;
   logic [NSRC-1:0] claim_mask;
   logic [NSRC-1:0] eligible;
   logic [3:0]      winner_id;
   logic [3:0]      claim_q;
   logic            meip_q;
   logic            busy_q;
   logic            ack_take;
   logic            withdraw;

   assign s_w      = sync_q[SYNC_STAGES-1];
   assign eligible = pend_q & src_en;
   assign ack_take = (state_q == ST_REQ) && intr_ack;
   // Ack outranks a same-cycle disable of the claimed source.
   assign withdraw = (state_q == ST_REQ) && !intr_ack && ((claim_mask & src_en) == '0);

   always_comb begin
      winner_id  = '0;
      claim_mask = '0;
      pend_d     = pend_q;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner_id = 4'(i + 1);
      end
      for (int i = 0; i < NSRC; i++) begin
         claim_mask[i] = (claim_q == 4'(i + 1));
         if (ack_take && claim_mask[i]) pend_d[i] = 1'b0;
         // Level lines are gated while their own claim is outstanding.
         if (edge_mode[i]) begin
            if (s_w[i] && !s_d_q[i]) pend_d[i] = 1'b1;
         end else begin
            if (s_w[i] && !(claim_mask[i] && (state_q != ST_IDLE))) pend_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         s_d_q   <= '0;
         pend_q  <= '0;
         claim_q <= '0;
         meip_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s_d_q  <= s_w;
         pend_q <= pend_d;
         case (state_q)
            ST_IDLE: begin
               claim_q <= winner_id;
               meip_q  <= (winner_id != '0);
               if (winner_id != '0) state_q <= ST_REQ;
            end
            ST_REQ: begin
               if (intr_ack) begin
                  meip_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SERVICE;
               end else if (withdraw) begin
                  meip_q  <= 1'b0;
                  claim_q <= '0;
                  state_q <= ST_IDLE;
               end
            end
            ST_SERVICE: begin
               if (complete) begin
                  busy_q  <= 1'b0;
                  claim_q <= '0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               meip_q  <= 1'b0;
               busy_q  <= 1'b0;
               claim_q <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign meip     = meip_q;
   assign claim_id = claim_q;
   assign busy     = busy_q;
   assign pending  = pend_q;

endmodule

`default_nettype wire
